// File: rtl/pipe_register.sv
// Multi-stage valid/ready pipeline register with bubble collapsing,
// synchronous flush and a registered occupancy count.
module pipe_register #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [DATA_WIDTH-1:0]        IN_DATA,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  output logic [DATA_WIDTH-1:0]        OUT_DATA,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  input  logic                         FLUSH,
  output logic [$clog2(DEPTH+1)-1:0]   COUNT
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]      v_q, v_d;
  logic [DEPTH-1:0]      adv, load, v_in;
  logic [DATA_WIDTH-1:0] d_q  [DEPTH];
  logic [DATA_WIDTH-1:0] d_d  [DEPTH];
  logic [DATA_WIDTH-1:0] d_in [DEPTH];
  logic [CW-1:0]         count_q, count_d;
  logic                  in_xfer, out_xfer;

  // An empty stage downstream breaks the stall chain.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = OUT_READY;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = !v_q[i+1] || adv[i+1];
    end
    load = ~v_q | adv;
  end

  always_comb begin
    v_in    = '0;
    d_in    = d_q;
    v_in[0] = IN_VALID;
    d_in[0] = IN_DATA;
    for (int i = 1; i < DEPTH; i++) begin
      v_in[i] = v_q[i-1];
      d_in[i] = d_q[i-1];
    end
  end

  assign IN_READY  = load[0] && !FLUSH;
  assign OUT_VALID = v_q[DEPTH-1] && !FLUSH;
  assign OUT_DATA  = d_q[DEPTH-1];
  assign COUNT     = count_q;
  assign in_xfer   = IN_VALID && IN_READY;
  assign out_xfer  = OUT_VALID && OUT_READY;

  always_comb begin
    v_d     = v_q;
    d_d     = d_q;
    count_d = count_q;
    if (FLUSH) begin
      v_d     = '0;
      count_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (load[i]) begin
          v_d[i] = v_in[i];
          // Empty slots keep their old data to avoid toggling.
          if (v_in[i]) d_d[i] = d_in[i];
        end
      end
      count_d = count_q + CW'(in_xfer) - CW'(out_xfer);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      v_q     <= '0;
      d_q     <= '{default: '0};
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      d_q     <= d_d;
      count_q <= count_d;
    end
  end

endmodule
